// File: rtl/cpu_pkg.sv
// Shared types for the cpu: FSM states, instruction field codes, shift codes,
// ALU operation selector and datapath control bundle.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_GET_A     = 3'd2,
      S_GET_B     = 3'd3,
      S_ALU       = 3'd4,
      S_WRITE_REG = 3'd5,
      S_WRITE_IMM = 3'd6
   } state_e;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_e;

   typedef enum logic [2:0] {
      ALU_MOV = 3'd0,
      ALU_ADD = 3'd1,
      ALU_CMP = 3'd2,
      ALU_AND = 3'd3,
      ALU_MVN = 3'd4
   } alu_op_e;

   typedef struct packed {
      logic load_a;
      logic load_b;
      logic load_c;
      logic load_flags;
      logic write_reg;
      logic write_imm;
   } dp_ctrl_t;

   function automatic logic [15:0] shift16(input logic [15:0] v, input shift_e sh);
      logic [15:0] r;
      case (sh)
         SH_LSL:  r = {v[14:0], 1'b0};
         SH_LSR:  r = {1'b0, v[15:1]};
         SH_ASR:  r = {v[15], v[15:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // MOV reg is the only non-ALU-opcode instruction that reaches the ALU state.
   function automatic alu_op_e decode_alu(input logic [2:0] opc, input logic [1:0] op);
      alu_op_e r;
      r = ALU_MOV;
      if (opc == OPC_ALU) begin
         case (op)
            OP_ADD:  r = ALU_ADD;
            OP_CMP:  r = ALU_CMP;
            OP_AND:  r = ALU_AND;
            default: r = ALU_MVN;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/cpu_datapath.sv
// cpu datapath: R0..R7, operand latches A/B, shifter, ALU, result register C
// and N/V/Z status flags. All sequencing comes from the controller in cpu.
module cpu_datapath
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  dp_ctrl_t    ctrl,
   input  alu_op_e     alu_op,
   input  logic [2:0]  rn,
   input  logic [2:0]  rd,
   input  logic [2:0]  rm,
   input  shift_e      sh,
   input  logic [7:0]  imm8,
   output logic [15:0] out,
   output logic        n_flag,
   output logic        v_flag,
   output logic        z_flag
);

   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] c_q, c_d;
   logic        n_q, n_d;
   logic        v_q, v_d;
   logic        z_q, z_d;

   logic [15:0] b_sh;
   logic [15:0] alu_res;
   logic        alu_v;

   assign b_sh = shift16(b_q, sh);

   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            alu_res = a_q + b_sh;
            alu_v   = (a_q[15] == b_sh[15]) && (alu_res[15] != a_q[15]);
         end
         ALU_CMP: begin
            alu_res = a_q - b_sh;
            alu_v   = (a_q[15] != b_sh[15]) && (alu_res[15] != a_q[15]);
         end
         ALU_AND: alu_res = a_q & b_sh;
         ALU_MVN: alu_res = ~b_sh;
         default: alu_res = b_sh;
      endcase
   end

   // Operands are latched in GET_A/GET_B, so Rd aliasing Rn/Rm is harmless.
   always_comb begin
      regs_d = regs_q;
      a_d    = ctrl.load_a ? regs_q[rn] : a_q;
      b_d    = ctrl.load_b ? regs_q[rm] : b_q;
      c_d    = ctrl.load_c ? alu_res : c_q;
      n_d    = n_q;
      v_d    = v_q;
      z_d    = z_q;
      if (ctrl.load_flags) begin
         n_d = alu_res[15];
         v_d = alu_v;
         z_d = (alu_res == 16'd0);
      end
      if (ctrl.write_reg) regs_d[rd] = c_q;
      if (ctrl.write_imm) regs_d[rn] = {{8{imm8[7]}}, imm8};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q <= '{default: 16'd0};
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         n_q    <= 1'b0;
         v_q    <= 1'b0;
         z_q    <= 1'b0;
      end else begin
         regs_q <= regs_d;
         a_q    <= a_d;
         b_q    <= b_d;
         c_q    <= c_d;
         n_q    <= n_d;
         v_q    <= v_d;
         z_q    <= z_d;
      end
   end

   assign out    = c_q;
   assign n_flag = n_q;
   assign v_flag = v_q;
   assign z_flag = z_q;

endmodule

// File: rtl/cpu.sv
// cpu top: instruction register and sequencing FSM around cpu_datapath.
// Build option CPU_STATUS_ALL_EN: every ALU-state op updates N/V/Z, not only CMP.
//
// state       | meaning
// WAIT        | idle, w=1, waits for s
// DECODE      | pick path from IR opcode/op
// GET_A       | latch Rn into A
// GET_B       | latch Rm into B
// ALU         | CMP: latch flags; others: load C
// WRITE_REG   | Rd <= C
// WRITE_IMM   | Rn <= sign-extended imm8
module cpu
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out,
   output logic        N,
   output logic        V,
   output logic        Z,
   output logic        w
);

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   dp_ctrl_t    ctrl;

   logic [2:0] opcode;
   logic [1:0] op;
   logic       is_mov_imm;
   logic       is_mov_reg;
   logic       is_alu;
   logic       is_cmp;

   assign opcode     = ir_q[15:13];
   assign op         = ir_q[12:11];
   assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
   assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
   assign is_alu     = (opcode == OPC_ALU);
   assign is_cmp     = is_alu && (op == OP_CMP);

   assign ir_d = load ? in : ir_q;

   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      case (state_q)
         S_WAIT: begin
            if (s) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)                             state_d = S_WRITE_IMM;
            else if (is_mov_reg || (is_alu && op == OP_MVN)) state_d = S_GET_B;
            else if (is_alu)                            state_d = S_GET_A;
            else                                        state_d = S_WAIT;
         end
         S_GET_A: begin
            ctrl.load_a = 1'b1;
            state_d     = S_GET_B;
         end
         S_GET_B: begin
            ctrl.load_b = 1'b1;
            state_d     = S_ALU;
         end
         S_ALU: begin
            if (is_cmp) begin
               ctrl.load_flags = 1'b1;
               state_d         = S_WAIT;
            end else begin
               ctrl.load_c = 1'b1;
`ifdef CPU_STATUS_ALL_EN
               ctrl.load_flags = 1'b1;
`else
               ctrl.load_flags = 1'b0;
`endif
               state_d = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            ctrl.write_reg = 1'b1;
            state_d        = S_WAIT;
         end
         S_WRITE_IMM: begin
            ctrl.write_imm = 1'b1;
            state_d        = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   assign w = (state_q == S_WAIT);

   cpu_datapath u_datapath (
      .clk    (clk),
      .reset  (reset),
      .ctrl   (ctrl),
      .alu_op (decode_alu(opcode, op)),
      .rn     (ir_q[10:8]),
      .rd     (ir_q[7:5]),
      .rm     (ir_q[2:0]),
      .sh     (shift_e'(ir_q[4:3])),
      .imm8   (ir_q[7:0]),
      .out    (out),
      .n_flag (N),
      .v_flag (V),
      .z_flag (Z)
   );

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: instruction-level model plus literal checks on
// results, flags, latency and asynchronous reset.
module tb_cpu;

   logic        clk = 1'b0;
   logic        reset;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic [15:0] out;
   logic        N, V, Z, w;

   cpu dut (
      .clk   (clk),
      .reset (reset),
      .s     (s),
      .load  (load),
      .in    (in),
      .out   (out),
      .N     (N),
      .V     (V),
      .Z     (Z),
      .w     (w)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_r [8];
   logic [15:0] m_c;
   logic        m_n, m_v, m_z;
   bit          check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
      m_c = 16'd0;
      m_n = 1'b0;
      m_v = 1'b0;
      m_z = 1'b0;
   endfunction

   // Executes one instruction on the model; returns edges from start to w=1.
   function automatic int model_exec(input logic [15:0] ins);
      logic [2:0]  opc, rn, rd, rm;
      logic [1:0]  op, sh;
      logic [15:0] a, b, res;
      int          wide;
      bit          ovf;
      opc = ins[15:13]; op = ins[12:11];
      rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
      a = m_r[rn];
      b = m_r[rm];
      if (sh == 2'd1)      b = b * 2;
      else if (sh == 2'd2) b = b / 2;
      else if (sh == 2'd3) b = 16'($signed(b) >>> 1);
      ovf = 1'b0;
      if (opc == 3'd6 && op == 2'd2) begin
         m_r[rn] = 16'($signed(ins[7:0]));
         return 3;
      end
      if (opc == 3'd6 && op == 2'd0) begin
         res = b;
      end else if (opc == 3'd5) begin
         case (op)
            2'd0: begin
               wide = int'($signed(a)) + int'($signed(b));
               res  = wide[15:0];
               ovf  = (wide > 32767) || (wide < -32768);
            end
            2'd1: begin
               wide = int'($signed(a)) - int'($signed(b));
               res  = wide[15:0];
               m_z  = (res == 16'd0);
               m_n  = res[15];
               m_v  = (wide > 32767) || (wide < -32768);
               return 5;
            end
            2'd2: res = a & b;
            default: res = ~b;
         endcase
      end else begin
         return 2;
      end
      m_c     = res;
      m_r[rd] = res;
`ifdef CPU_STATUS_ALL_EN
      m_z = (res == 16'd0);
      m_n = res[15];
      m_v = ovf;
`endif
      return (opc == 3'd5 && (op == 2'd0 || op == 2'd2)) ? 6 : 5;
   endfunction

   always @(negedge clk) begin
      if (check_en) begin
         chk("mdl_w", {31'd0, w}, 32'd1);
         chk("mdl_out", {16'd0, out}, {16'd0, m_c});
         chk("mdl_n", {31'd0, N}, {31'd0, m_n});
         chk("mdl_v", {31'd0, V}, {31'd0, m_v});
         chk("mdl_z", {31'd0, Z}, {31'd0, m_z});
      end
   end

   task automatic run(input logic [15:0] ins, input bit do_load, input string name);
      int edges, exp_lat;
      check_en = 1'b0;
      @(negedge clk);
      in   = ins;
      load = do_load;
      @(negedge clk);
      load = 1'b0;
      s    = 1'b1;
      @(posedge clk);
      #1;
      s     = 1'b0;
      edges = 1;
      while (!w && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      exp_lat = do_load ? model_exec(ins) : model_exec(16'h0000);
      chk({name, "_lat"}, edges, exp_lat);
      check_en = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      s     = 1'b0;
      load  = 1'b0;
      in    = 16'h0000;
      model_reset();
      #1;
      chk("rst_w", {31'd0, w}, 32'd1);
      chk("rst_out", {16'd0, out}, 32'd0);
      chk("rst_flags", {29'd0, N, V, Z}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_en = 1'b1;
      @(negedge clk);

      run(16'hD007, 1'b1, "mov_r0_7");
      chk("mov_r0_out", {16'd0, out}, 32'd0);
      chk("mov_r0_w", {31'd0, w}, 32'd1);
      run(16'hD102, 1'b1, "mov_r1_2");
      chk("mov_r1_out", {16'd0, out}, 32'd0);

      run(16'hA148, 1'b1, "add_r2");
      chk("add_r2_out", {16'd0, out}, 32'd16);
      run(16'hC062, 1'b1, "mov_r3_r2");
      chk("mov_r3_out", {16'd0, out}, 32'd16);

      run(16'hAB02, 1'b1, "cmp_r3_r2");
      chk("cmp_eq_nvz", {29'd0, N, V, Z}, 32'b001);
      chk("cmp_eq_out", {16'd0, out}, 32'd16);
      run(16'hD488, 1'b1, "mov_r4_m120");
      run(16'hAC03, 1'b1, "cmp_r4_r3");
      chk("cmp_neg_nvz", {29'd0, N, V, Z}, 32'b100);

      run(16'hD580, 1'b1, "mov_r5_80");
      run(16'hB5D5, 1'b1, "and_r6");
      chk("and_r6_out", {16'd0, out}, 32'h7F80);
      run(16'hD7FF, 1'b1, "mov_r7_m1");
      run(16'hB8F7, 1'b1, "mvn_r7");
      chk("mvn_r7_out", {16'd0, out}, 32'h8000);
      run(16'hAE07, 1'b1, "cmp_ovf");
      chk("cmp_ovf_nvz", {29'd0, N, V, Z}, 32'b110);

      run(16'hD6FC, 1'b1, "mov_r6_fc");
      run(16'hB86E, 1'b1, "mvn_lsl");
      chk("mvn_lsl_out", {16'd0, out}, 32'h0007);
      run(16'hB8FE, 1'b1, "mvn_asr");
      chk("mvn_asr_out", {16'd0, out}, 32'h0001);

      run(16'h0000, 1'b1, "undef");
      chk("undef_out", {16'd0, out}, 32'h0001);

      // Reset while ADD R2,R1,R0 sits in WRITE_REG with C already loaded.
      run(16'hD007, 1'b1, "mov_r0_7b");
      run(16'hD102, 1'b1, "mov_r1_2b");
      check_en = 1'b0;
      @(negedge clk);
      in   = 16'hA140;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      s    = 1'b1;
      @(posedge clk);
      #1;
      s = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("mid_add_out", {16'd0, out}, 32'd9);
      chk("mid_add_w", {31'd0, w}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_mid_w", {31'd0, w}, 32'd1);
      chk("rst_mid_out", {16'd0, out}, 32'd0);
      model_reset();
      s    = 1'b1;
      load = 1'b1;
      in   = 16'hD07F;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_w", {31'd0, w}, 32'd1);
      @(negedge clk);
      s    = 1'b0;
      load = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_en = 1'b1;
      run(16'h0000, 1'b0, "post_rst_ir");
      run(16'hC062, 1'b1, "post_rst_r2");
      chk("post_rst_r2_out", {16'd0, out}, 32'd0);

      check_en = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: s  input  1  start; sampled only in WAIT.
REQ-004 SHALL have port: load  input  1  loads `in` into instruction register (IR) on rising edge, in any state.
REQ-005 SHALL have port: in  input  16  instruction word.
REQ-006 SHALL have port: out  output  16  result register C contents.
REQ-007 SHALL have ports: N, V, Z  output  1 each  status flags (negative, signed overflow, zero).
REQ-008 SHALL have port: w  output  1  high only when FSM is in WAIT.

Function
REQ-009 SHALL decode IR fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
REQ-010 SHALL contain eight 16-bit registers R0..R7.
REQ-011 SHALL apply shifter to Rm value: sh 00 none, 01 LSL#1 (zero in), 10 LSR#1 (zero in), 11 ASR#1 (MSB copied).
REQ-012 SHALL implement MOV Rn,#imm8 (opcode 110, op 10): Rn <= sign-extended imm8; C and flags unchanged.
REQ-013 SHALL implement MOV Rd,Rm{,sh} (110, op 00): C <= 0 + shifted Rm; Rd <= C.
REQ-014 SHALL implement ADD Rd,Rn,Rm{,sh} (101, op 00): C <= Rn + shifted Rm, 16-bit wrap; Rd <= C.
REQ-015 SHALL implement CMP Rn,Rm{,sh} (101, op 01): compute Rn - shifted Rm; set Z (result==0), N (result[15]), V (signed overflow of subtraction); C and registers unchanged.
REQ-016 SHALL implement AND Rd,Rn,Rm{,sh} (101, op 10): C <= Rn & shifted Rm; Rd <= C.
REQ-017 SHALL implement MVN Rd,Rm{,sh} (101, op 11): C <= ~(shifted Rm); Rd <= C.
REQ-018 SHALL use FSM states WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM.
REQ-019 SHALL transition WAIT->DECODE when s=1 at edge; otherwise stay in WAIT.
REQ-020 SHALL transition DECODE->WRITE_IMM (MOV imm), ->GET_B (MOV reg, MVN), ->GET_A (ADD, CMP, AND), ->WAIT (any other encoding, no state change).
REQ-021 SHALL transition GET_A->GET_B->ALU; ALU->WAIT for CMP, ALU->WRITE_REG otherwise; WRITE_REG->WAIT; WRITE_IMM->WAIT.
REQ-022 SHALL latch flags in ALU state for CMP only; C loaded in ALU state for non-CMP ops.
REQ-023 SHALL give latency: MOV imm 3 edges from start to w=1; MOV reg/MVN 5; CMP 5; ADD/AND 6.
REQ-024 SHALL, if load asserts mid-instruction, update IR but finish current instruction with decoded fields taken from IR each cycle (software must not do this; behaviour defined as above).
REQ-025 SHALL treat Rd==Rn or Rd==Rm correctly (operands read before write).

Reset
REQ-026 SHALL, on reset low, immediately force FSM to WAIT, and IR, R0..R7, C, N, V, Z to 0; w=1 during and after reset.
REQ-027 SHALL ignore s and load while reset is low.

Configuration
REQ-028 SHALL support macro CPU_STATUS_ALL_EN: defined -> ADD, AND, MVN and MOV reg also update Z/N/V from their result (V=ADD overflow, 0 for others); undefined -> only CMP updates flags.

Structure
REQ-029 SHALL place state enum, opcode/op codes and shift codes in package cpu_pkg.
REQ-030 SHALL split register file, shifter, ALU, C and status registers into sub-module cpu_datapath; FSM and IR stay in cpu.

Verification
REQ-031 SHALL test: reset, MOV R0,#7 then MOV R1,#2 -> out=0, w=1 after each.
REQ-032 SHALL test: ADD R2,R1,R0,LSL#1 (0xA148) -> out=16; MOV R3,R2 (0xC062) -> out=16.
REQ-033 SHALL test: CMP R3,R2 (0xAB02) -> Z=1,N=0,V=0; MOV R4,#-120 then CMP R4,R3 -> Z=0,N=1,V=0.
REQ-034 SHALL test: R6=0x7F80, R7=0x8000, CMP R6-R7 overflow case -> V=1.
REQ-035 SHALL test: R6=0xFFFC, MVN R3,R6,LSL#1 -> out=0x0007; MVN R7,R6,ASR#1 -> out=0x0001.
REQ-036 SHALL test: reset asserted mid-ADD -> w=1 immediately, out=0, destination register unchanged.
